regblock_arbiter: RTL
=====================

# regblock_arbiter

Two-port access controller that shares a single register block between two independent requesters (A and B). It arbitrates per-cycle read/write requests round-robin, supports a bounded lock so one requester can issue back-to-back transactions, and returns registered read responses. It sits in front of the `regfile_core` storage and is the first multi-requester block in the `regblock` family. It is checked with the same two-instance miter flow as the rest of the family.

## Interface
- `NREGS`, 8: number of registers; must be a power of two, at least 2.
- `WIDTH`, 32: register data width.
- `MAX_LOCK`, 4: maximum consecutive grants under lock, at least 1.
- `AW`, `$clog2(NREGS)`: address width (derived, not overridden).

Ports:
- `clk` in 1: clock, all state on posedge.
- `rst` in 1: **synchronous, active-low** reset.
- `a_req_valid` / `b_req_valid` in 1: request present.
- `a_req_ready` / `b_req_ready` out 1: grant; the transaction happens when valid & ready.
- `a_req_we` / `b_req_we` in 1: 1 = write, 0 = read.
- `a_req_lock` / `b_req_lock` in 1: request to keep the grant for the next transaction.
- `a_req_addr` / `b_req_addr` in AW: register index.
- `a_req_wdata` / `b_req_wdata` in WIDTH: write data.
- `a_rsp_valid` / `b_rsp_valid` out 1: one-cycle response pulse.
- `a_rsp_rdata` / `b_rsp_rdata` out WIDTH: read data; 0 for write acks.

## Operation
- At most one handshake per cycle, across both ports.
- State `last` (1 bit) records the port granted most recently.
- FSM states:
  - `IDLE`: only A valid → grant A. Only B valid → grant B. Both valid → grant the port that is not `last`.
  - `LOCK_A` / `LOCK_B`: only the owner can be granted. The other port's ready stays 0 even if the owner is idle.
- Transitions:
  - A handshake with lock=1 in `IDLE` → `LOCK_x`, and `lock_cnt` is set to 1.
  - In `LOCK_x`, a handshake with lock=1 increments `lock_cnt`.
  - In `LOCK_x`, a handshake with lock=0 → `IDLE`.
  - A handshake that brings `lock_cnt` to `MAX_LOCK` → `IDLE`, whatever the lock value (forced release).
  - On every exit from `LOCK_x`, `last` is set to x, so the other port wins the next contention.
- `lock_cnt` width: `$clog2(MAX_LOCK+1)`. It saturates and never wraps.
- Write: the register is updated at the handshake edge. The write ack (`rsp_valid`=1, `rdata`=0) appears the next cycle on the issuing port.
- Read: the register value is sampled at the handshake edge and returned with `rsp_valid` the next cycle.
- Responses have no backpressure. A requester must accept the pulse.
- A read of a register written in the previous cycle returns the new value (no forwarding is needed, because the write has already landed).
- Both ports valid on the same address in the same cycle: only the granted port's transaction occurs. The loser retries, holding valid.

Reset, while `rst`=0:
- All registers are 0; state `IDLE`; `last` = B, so A wins the first contention; `lock_cnt` = 0.
- Both ready = 0, both `rsp_valid` = 0, both `rsp_rdata` = 0.
- Reset asserted mid-lock or with a response pending:
  - The lock is abandoned.
  - The pending response is dropped: `rsp_valid` is 0 in the cycle after reset deasserts.

## Timing
- Ready is combinational from valid, FSM state and `last`. There is no combinational path from the `rsp_*` signals.
- Request-to-response latency: exactly 1 cycle after the handshake.
- Throughput: 1 transaction per cycle in aggregate.
- Under continuous contention with no locks, grants alternate A, B, A, B.
- Forced release: after `MAX_LOCK` consecutive owner grants, the other port (if valid) is granted on the very next cycle.

## Structure
- Package `regblock_arb_pkg` holds:
  - the `arb_state_e` enum (`IDLE`, `LOCK_A`, `LOCK_B`);
  - the `port_e` enum (`PORT_A`, `PORT_B`);
  - a `req_t` struct (we, lock, addr, wdata).
- Sub-module `regfile_core`: `NREGS`×`WIDTH` storage with a single write/read port and registered read data, reset to 0.
- The arbiter holds the FSM, `last`, `lock_cnt`, the response-port select register and the response valid registers.

## Test plan
- **Reset:** drive `rst`=0 for 2 cycles with both valid → both ready = 0 and both `rsp_valid` = 0. Then A writes 0xDEADBEEF to reg 3 and B reads reg 3 on the next cycle → B `rsp_rdata` = 0xDEADBEEF, one cycle after B's handshake.
- **Contention:** both valid continuously, no lock, 6 cycles → grant order A, B, A, B, A, B. Each `rsp_valid` lands on the correct port one cycle later.
- **Lock with voluntary release:** A locks for 3 transactions, then sends lock=0, while B is valid throughout → B ready = 0 for 4 cycles, then B is granted on the next cycle.
- **Forced release:** A holds lock=1 continuously with `MAX_LOCK`=4 → exactly 4 A grants, then B is granted, then A again.
- **Same-address collision:** A writes 0x1 to reg 5 while B writes 0x2 to reg 5 in the same cycle, with `last`=B → A wins. B retries next cycle → final reg 5 = 0x2, and both write acks return rdata 0.
- **Reset mid-lock:** assert `rst`=0 during `LOCK_B` with a read response pending → no `rsp_valid` appears. After release, A wins the first contention and all registers read back 0.

Source files
------------

// File: rtl/regblock_arbiter_pkg.sv
// Shared types for the regblock two-port arbiter.
// Request bundle fields are sized for the widest supported register block.
package regblock_arb_pkg;

    localparam int REQ_AW = 16;
    localparam int REQ_DW = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    typedef struct packed {
        logic              we;
        logic              lock;
        logic [REQ_AW-1:0] addr;
        logic [REQ_DW-1:0] wdata;
    } req_t;

endpackage

// File: rtl/regblock_arbiter_regfile.sv
// Register storage: one write/read port, registered read data.
// A read in the same cycle as a write to that index returns the old value.
module regfile_core #(
    parameter int NREGS = 8,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/regblock_arbiter.sv
// Two-port round-robin access controller with bounded lock in front of
// regfile_core; responses return one cycle after the handshake.
module regblock_arbiter
    import regblock_arb_pkg::*;
#(
    parameter int  NREGS    = 8,
    parameter int  WIDTH    = 32,
    parameter int  MAX_LOCK = 4,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_req_valid,
    output logic             a_req_ready,
    input  logic             a_req_we,
    input  logic             a_req_lock,
    input  logic [AW-1:0]    a_req_addr,
    input  logic [WIDTH-1:0] a_req_wdata,
    output logic             a_rsp_valid,
    output logic [WIDTH-1:0] a_rsp_rdata,
    input  logic             b_req_valid,
    output logic             b_req_ready,
    input  logic             b_req_we,
    input  logic             b_req_lock,
    input  logic [AW-1:0]    b_req_addr,
    input  logic [WIDTH-1:0] b_req_wdata,
    output logic             b_rsp_valid,
    output logic [WIDTH-1:0] b_rsp_rdata
);

    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_LOCK);

    arb_state_e       state, state_n;
    port_e            last, last_n;
    logic [CW-1:0]    lock_cnt, lock_cnt_n, cnt_inc;
    logic             gnt_a, gnt_b, hs;
    req_t             req_a, req_b, req_sel;
    logic             rsp_vld, rsp_we;
    port_e            rsp_port;
    logic [WIDTH-1:0] core_rdata;

    assign req_a = '{we: a_req_we, lock: a_req_lock,
                     addr: REQ_AW'(a_req_addr),
                     wdata: REQ_DW'(a_req_wdata)};
    assign req_b = '{we: b_req_we, lock: b_req_lock,
                     addr: REQ_AW'(b_req_addr),
                     wdata: REQ_DW'(b_req_wdata)};

    assign hs      = gnt_a | gnt_b;
    assign req_sel = gnt_b ? req_b : req_a;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            last     <= PORT_B;
            lock_cnt <= '0;
            rsp_vld  <= 1'b0;
            rsp_we   <= 1'b0;
            rsp_port <= PORT_A;
        end else begin
            state    <= state_n;
            last     <= last_n;
            lock_cnt <= lock_cnt_n;
            rsp_vld  <= hs;
            rsp_we   <= req_sel.we;
            rsp_port <= gnt_b ? PORT_B : PORT_A;
        end
    end

    // Grants only ever go to the owner while locked, so last tracks it.
    always_comb begin
        state_n    = state;
        last_n     = last;
        lock_cnt_n = lock_cnt;
        cnt_inc    = (lock_cnt == CNT_MAX) ? lock_cnt : lock_cnt + 1'b1;
        if (hs) begin
            last_n = gnt_b ? PORT_B : PORT_A;
            if (req_sel.lock && cnt_inc != CNT_MAX) begin
                state_n    = gnt_b ? LOCK_B : LOCK_A;
                lock_cnt_n = cnt_inc;
            end else begin
                state_n    = IDLE;
                lock_cnt_n = '0;
            end
        end
    end

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (rst) begin
            unique case (state)
                IDLE: begin
                    gnt_a = a_req_valid && (!b_req_valid || last == PORT_B);
                    gnt_b = b_req_valid && (!a_req_valid || last == PORT_A);
                end
                LOCK_A:  gnt_a = a_req_valid;
                LOCK_B:  gnt_b = b_req_valid;
                default: ;
            endcase
        end
    end

    assign a_req_ready = gnt_a;
    assign b_req_ready = gnt_b;

    regfile_core #(
        .NREGS (NREGS),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .we    (hs && req_sel.we),
        .addr  (AW'(req_sel.addr)),
        .wdata (WIDTH'(req_sel.wdata)),
        .rdata (core_rdata)
    );

    // Outputs are held quiet while reset is asserted, dropping any pending pulse.
    assign a_rsp_valid = rst && rsp_vld && rsp_port == PORT_A;
    assign b_rsp_valid = rst && rsp_vld && rsp_port == PORT_B;
    assign a_rsp_rdata = (a_rsp_valid && !rsp_we) ? core_rdata : '0;
    assign b_rsp_rdata = (b_rsp_valid && !rsp_we) ? core_rdata : '0;

endmodule
